// File: rtl/conv_input_buffer_if.sv
// AXI-Stream sample channel feeding the convolution input buffer.
// TUSER carries {K, new_W} and is meaningful only on the first beat of a matrix.
interface conv_input_buffer_if #(
    parameter int INW    = 24,
    parameter int K_BITS = 4
);
    logic [INW-1:0] AXIS_TDATA;
    logic           AXIS_TVALID;
    logic [K_BITS:0] AXIS_TUSER;
    logic           AXIS_TREADY;

    modport master (output AXIS_TDATA, output AXIS_TVALID, output AXIS_TUSER, input AXIS_TREADY);
    modport slave  (input AXIS_TDATA, input AXIS_TVALID, input AXIS_TUSER, output AXIS_TREADY);
endinterface

// File: rtl/conv_input_buffer.sv
// Input buffer for the 2D convolution accelerator: captures W, B and X from one stream,
// holds them stable for the compute stage, and optionally reuses W/K/B across X matrices.
module conv_input_buffer #(
    parameter int INW  = 24,
    parameter int R    = 16,
    parameter int C    = 17,
    parameter int MAXK = 9,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int X_ADDR_BITS = $clog2(R * C),
    localparam int W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_input_buffer_if.slave     s_axis,
    output logic                   inputs_loaded,
    input  logic                   compute_finished,
    output logic [K_BITS-1:0]      K,
    output logic [INW-1:0]         B,
    input  logic [X_ADDR_BITS-1:0] X_read_addr,
    output logic [INW-1:0]         X_data,
    input  logic [W_ADDR_BITS-1:0] W_read_addr,
    output logic [INW-1:0]         W_data
);

    // Counter must hold both R*C-1 and the full K*K product.
    localparam int CNT_BITS = (X_ADDR_BITS > 2 * K_BITS) ? X_ADDR_BITS : 2 * K_BITS;
    localparam logic [CNT_BITS-1:0] X_LAST = CNT_BITS'(R * C - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_B,
        LOAD_X,
        READY
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [K_BITS-1:0]     k_q, k_d;
    logic [INW-1:0]        b_q, b_d;

    logic                  w_we, x_we;
    logic [W_ADDR_BITS-1:0] w_waddr;
    logic [X_ADDR_BITS-1:0] x_waddr;
    logic                  accept;
    logic [K_BITS-1:0]     tuser_k;
    logic [CNT_BITS-1:0]   k_ext, kk_last;

    logic [INW-1:0] w_mem [MAXK*MAXK];
    logic [INW-1:0] x_mem [R*C];
    logic [INW-1:0] x_rdata_q, w_rdata_q;

    assign s_axis.AXIS_TREADY = (state_q != READY);
    assign inputs_loaded      = (state_q == READY);
    assign accept             = s_axis.AXIS_TVALID && s_axis.AXIS_TREADY;
    assign tuser_k            = s_axis.AXIS_TUSER[K_BITS:1];
    assign k_ext              = {{(CNT_BITS-K_BITS){1'b0}}, k_q};
    assign kk_last            = k_ext * k_ext - CNT_BITS'(1);
    assign K                  = k_q;
    assign B                  = b_q;
    assign X_data             = x_rdata_q;
    assign W_data             = w_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        b_d     = b_q;
        w_we    = 1'b0;
        x_we    = 1'b0;
        w_waddr = cnt_q[W_ADDR_BITS-1:0];
        x_waddr = cnt_q[X_ADDR_BITS-1:0];
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = CNT_BITS'(1);
                    if (s_axis.AXIS_TUSER[0]) begin
                        k_d     = tuser_k;
                        w_we    = 1'b1;
                        w_waddr = '0;
                        state_d = (tuser_k == K_BITS'(1)) ? LOAD_B : LOAD_W;
                    end else begin
                        x_we    = 1'b1;
                        x_waddr = '0;
                        if (X_LAST == '0) begin
                            cnt_d   = '0;
                            state_d = READY;
                        end else begin
                            state_d = LOAD_X;
                        end
                    end
                end
            end
            LOAD_W: begin
                if (accept) begin
                    w_we = 1'b1;
                    if (cnt_q == kk_last) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    b_d     = s_axis.AXIS_TDATA;
                    cnt_d   = '0;
                    state_d = LOAD_X;
                end
            end
            LOAD_X: begin
                if (accept) begin
                    x_we = 1'b1;
                    if (cnt_q == X_LAST) begin
                        cnt_d   = '0;
                        state_d = READY;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end
            READY: begin
                if (compute_finished) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Memories are intentionally not reset; reads return pre-write contents on a collision.
    always_ff @(posedge clk) begin
        if (w_we) begin
            w_mem[w_waddr] <= s_axis.AXIS_TDATA;
        end
        if (x_we) begin
            x_mem[x_waddr] <= s_axis.AXIS_TDATA;
        end
        x_rdata_q <= x_mem[X_read_addr];
        w_rdata_q <= w_mem[W_read_addr];
    end

endmodule

// File: tb/tb_conv_input_buffer.sv
// Directed bench for conv_input_buffer with R=4, C=5, MAXK=9.
module tb_conv_input_buffer;
    localparam int INW = 24;
    localparam int R   = 4;
    localparam int C   = 5;
    localparam int NX  = R * C;

    logic            clk;
    logic            reset;
    logic            inputs_loaded;
    logic            compute_finished;
    logic [3:0]      K;
    logic [INW-1:0]  B;
    logic [4:0]      X_read_addr;
    logic [INW-1:0]  X_data;
    logic [6:0]      W_read_addr;
    logic [INW-1:0]  W_data;

    int errors = 0;
    int checks = 0;

    conv_input_buffer_if #(.INW(INW), .K_BITS(4)) axis ();

    conv_input_buffer #(.INW(INW), .R(R), .C(C), .MAXK(9)) dut (
        .clk              (clk),
        .reset            (reset),
        .s_axis           (axis),
        .inputs_loaded    (inputs_loaded),
        .compute_finished (compute_finished),
        .K                (K),
        .B                (B),
        .X_read_addr      (X_read_addr),
        .X_data           (X_data),
        .W_read_addr      (W_read_addr),
        .W_data           (W_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams one matrix (or its first max_beats beats); returns elapsed cycles.
    task automatic load(input bit new_w, input int k, input int w0, input int b, input int x0,
                        input bit gaps, input int max_beats, output int cycles);
        int total;
        int val;
        int n;
        total  = new_w ? (k * k + 1 + NX) : NX;
        cycles = 0;
        for (int i = 0; i < total && i < max_beats; i++) begin
            if (new_w) val = (i < k * k) ? (w0 + i) : (i == k * k) ? b : (x0 + i - k * k - 1);
            else       val = x0 + i;
            if (gaps && $urandom_range(1) == 1) begin
                axis.AXIS_TVALID = 1'b0;
                tick();
                cycles++;
            end
            axis.AXIS_TDATA  = INW'(val);
            axis.AXIS_TUSER  = (i == 0) ? {k[3:0], new_w} : 5'h1F;
            axis.AXIS_TVALID = 1'b1;
            n = 0;
            while (!axis.AXIS_TREADY && n < 100) begin
                tick();
                cycles++;
                n++;
            end
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL load_timeout: beat %0d never accepted within 100 cycles", i);
            end
            tick();
            cycles++;
        end
        axis.AXIS_TVALID = 1'b0;
    endtask

    task automatic read_x(input int addr, output logic [INW-1:0] d);
        X_read_addr = 5'(addr);
        tick();
        d = X_data;
    endtask

    task automatic read_w(input int addr, output logic [INW-1:0] d);
        W_read_addr = 7'(addr);
        tick();
        d = W_data;
    endtask

    task automatic pulse_finish();
        compute_finished = 1'b1;
        tick();
        compute_finished = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (axis.AXIS_TREADY !== 1'b1) begin
            errors++; $display("FAIL reset_tready: got %b expected 1", axis.AXIS_TREADY);
        end
        checks++;
        if (inputs_loaded !== 1'b0) begin
            errors++; $display("FAIL reset_loaded: got %b expected 0", inputs_loaded);
        end
        checks++;
        if (K !== 4'd0) begin
            errors++; $display("FAIL reset_k: got %0d expected 0", K);
        end
        checks++;
        if (B !== '0) begin
            errors++; $display("FAIL reset_b: got %0h expected 0", B);
        end
    endtask

    task automatic test_full_load();
        int cyc;
        logic [INW-1:0] d;
        load(1'b1, 3, 1, -7, 0, 1'b0, 1000, cyc);
        checks++;
        if (cyc !== 30) begin
            errors++; $display("FAIL full_cycles: got %0d expected 30", cyc);
        end
        checks++;
        if (axis.AXIS_TREADY !== 1'b0) begin
            errors++; $display("FAIL full_tready_drop: got %b expected 0", axis.AXIS_TREADY);
        end
        checks++;
        if (inputs_loaded !== 1'b1) begin
            errors++; $display("FAIL full_loaded: got %b expected 1", inputs_loaded);
        end
        checks++;
        if (K !== 4'd3) begin
            errors++; $display("FAIL full_k: got %0d expected 3", K);
        end
        checks++;
        if (B !== 24'hFFFFF9) begin
            errors++; $display("FAIL full_b: got %0h expected fffff9", B);
        end
        read_x(13, d);
        checks++;
        if (d !== 24'd13) begin
            errors++; $display("FAIL full_x13: got %0d expected 13", d);
        end
        read_w(8, d);
        checks++;
        if (d !== 24'd9) begin
            errors++; $display("FAIL full_w8: got %0d expected 9", d);
        end
    endtask

    task automatic test_reuse_w();
        int cyc;
        logic [INW-1:0] d;
        pulse_finish();
        checks++;
        if (inputs_loaded !== 1'b0 || axis.AXIS_TREADY !== 1'b1) begin
            errors++; $display("FAIL reuse_idle: loaded=%b tready=%b expected 0/1", inputs_loaded, axis.AXIS_TREADY);
        end
        load(1'b0, 3, 0, 0, 100, 1'b0, 1000, cyc);
        checks++;
        if (cyc !== NX || inputs_loaded !== 1'b1) begin
            errors++; $display("FAIL reuse_cycles: got %0d loaded=%b expected %0d/1", cyc, inputs_loaded, NX);
        end
        checks++;
        if (K !== 4'd3 || B !== 24'hFFFFF9) begin
            errors++; $display("FAIL reuse_kb: got K=%0d B=%0h expected 3/fffff9", K, B);
        end
        for (int i = 0; i < 9; i++) begin
            read_w(i, d);
            checks++;
            if (d !== 24'(i + 1)) begin
                errors++; $display("FAIL reuse_w[%0d]: got %0d expected %0d", i, d, i + 1);
            end
        end
        read_x(0, d);
        checks++;
        if (d !== 24'd100) begin
            errors++; $display("FAIL reuse_x0: got %0d expected 100", d);
        end
        read_x(19, d);
        checks++;
        if (d !== 24'd119) begin
            errors++; $display("FAIL reuse_x19: got %0d expected 119", d);
        end
    endtask

    task automatic test_ready_block();
        int cyc;
        logic [INW-1:0] d;
        axis.AXIS_TDATA  = 24'd500;
        axis.AXIS_TUSER  = 5'b0;
        axis.AXIS_TVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (axis.AXIS_TREADY !== 1'b0 || inputs_loaded !== 1'b1) begin
                errors++; $display("FAIL block_ready[%0d]: tready=%b loaded=%b expected 0/1", i, axis.AXIS_TREADY, inputs_loaded);
            end
        end
        read_x(0, d);
        checks++;
        if (d !== 24'd100) begin
            errors++; $display("FAIL block_x0: got %0d expected 100", d);
        end
        pulse_finish();
        checks++;
        if (axis.AXIS_TREADY !== 1'b1 || inputs_loaded !== 1'b0) begin
            errors++; $display("FAIL block_release: tready=%b loaded=%b expected 1/0", axis.AXIS_TREADY, inputs_loaded);
        end
        load(1'b0, 3, 0, 0, 500, 1'b0, 1000, cyc);
        checks++;
        if (cyc !== NX) begin
            errors++; $display("FAIL block_cycles: got %0d expected %0d", cyc, NX);
        end
        read_x(0, d);
        checks++;
        if (d !== 24'd500) begin
            errors++; $display("FAIL block_x0_new: got %0d expected 500", d);
        end
        read_x(19, d);
        checks++;
        if (d !== 24'd519) begin
            errors++; $display("FAIL block_x19_new: got %0d expected 519", d);
        end
    endtask

    task automatic test_gaps();
        int cyc;
        logic [INW-1:0] d;
        pulse_finish();
        load(1'b1, 3, 11, 5, 40, 1'b1, 1000, cyc);
        checks++;
        if (inputs_loaded !== 1'b1 || K !== 4'd3 || B !== 24'd5) begin
            errors++; $display("FAIL gaps_state: loaded=%b K=%0d B=%0d expected 1/3/5", inputs_loaded, K, B);
        end
        for (int i = 0; i < 9; i++) begin
            read_w(i, d);
            checks++;
            if (d !== 24'(11 + i)) begin
                errors++; $display("FAIL gaps_w[%0d]: got %0d expected %0d", i, d, 11 + i);
            end
        end
        for (int i = 0; i < NX; i++) begin
            read_x(i, d);
            checks++;
            if (d !== 24'(40 + i)) begin
                errors++; $display("FAIL gaps_x[%0d]: got %0d expected %0d", i, d, 40 + i);
            end
        end
    endtask

    task automatic test_k1();
        int cyc;
        logic [INW-1:0] d;
        pulse_finish();
        load(1'b1, 1, 5, 2, 60, 1'b0, 1000, cyc);
        checks++;
        if (cyc !== 22 || inputs_loaded !== 1'b1) begin
            errors++; $display("FAIL k1_cycles: got %0d loaded=%b expected 22/1", cyc, inputs_loaded);
        end
        checks++;
        if (K !== 4'd1 || B !== 24'd2) begin
            errors++; $display("FAIL k1_kb: got K=%0d B=%0d expected 1/2", K, B);
        end
        read_w(0, d);
        checks++;
        if (d !== 24'd5) begin
            errors++; $display("FAIL k1_w0: got %0d expected 5", d);
        end
        read_w(1, d);
        checks++;
        if (d !== 24'd12) begin
            errors++; $display("FAIL k1_w1_kept: got %0d expected 12", d);
        end
        read_x(0, d);
        checks++;
        if (d !== 24'd60) begin
            errors++; $display("FAIL k1_x0: got %0d expected 60", d);
        end
        read_x(19, d);
        checks++;
        if (d !== 24'd79) begin
            errors++; $display("FAIL k1_x19: got %0d expected 79", d);
        end
    endtask

    task automatic test_reset_midload();
        int cyc;
        logic [INW-1:0] d;
        pulse_finish();
        load(1'b1, 3, 1, -7, 0, 1'b0, 12, cyc);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (axis.AXIS_TREADY !== 1'b1 || inputs_loaded !== 1'b0) begin
            errors++; $display("FAIL midrst_hs: tready=%b loaded=%b expected 1/0", axis.AXIS_TREADY, inputs_loaded);
        end
        checks++;
        if (K !== 4'd0 || B !== '0) begin
            errors++; $display("FAIL midrst_kb: got K=%0d B=%0h expected 0/0", K, B);
        end
        load(1'b1, 2, 7, -1, 300, 1'b0, 1000, cyc);
        checks++;
        if (cyc !== 25 || inputs_loaded !== 1'b1) begin
            errors++; $display("FAIL midrst_cycles: got %0d loaded=%b expected 25/1", cyc, inputs_loaded);
        end
        checks++;
        if (K !== 4'd2 || B !== 24'hFFFFFF) begin
            errors++; $display("FAIL midrst_kb2: got K=%0d B=%0h expected 2/ffffff", K, B);
        end
        for (int i = 0; i < 4; i++) begin
            read_w(i, d);
            checks++;
            if (d !== 24'(7 + i)) begin
                errors++; $display("FAIL midrst_w[%0d]: got %0d expected %0d", i, d, 7 + i);
            end
        end
        for (int i = 0; i < NX; i += 6) begin
            read_x(i, d);
            checks++;
            if (d !== 24'(300 + i)) begin
                errors++; $display("FAIL midrst_x[%0d]: got %0d expected %0d", i, d, 300 + i);
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        compute_finished = 1'b0;
        axis.AXIS_TVALID = 1'b0;
        axis.AXIS_TDATA  = '0;
        axis.AXIS_TUSER  = '0;
        X_read_addr      = '0;
        W_read_addr      = '0;
        test_reset();
        test_full_load();
        test_reuse_w();
        test_ready_block();
        test_gaps();
        test_k1();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_input_buffer.md
Name: conv_input_buffer

Overview:
- Upstream stage of the 2D convolution accelerator. Accepts one AXI-Stream of signed samples carrying the weight matrix W (KxK), the bias B and the input matrix X (RxC).
- Stores W and X in single-port-write, synchronous-read memories and holds K and B in registers.
- Raises inputs_loaded for the compute stage, then waits for compute_finished before accepting the next matrix.
- Supports reusing the stored W/B across several X matrices.

Parameters:
- INW, 24, sample width (two's complement).
- R, 16, rows of X.
- C, 17, columns of X.
- MAXK, 9, maximum kernel size.
- K_BITS (local), $clog2(MAXK+1), width of K.
- X_ADDR_BITS (local), $clog2(R*C), X address width.
- W_ADDR_BITS (local), $clog2(MAXK*MAXK), W address width.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- AXIS_TDATA  in  INW  sample value
- AXIS_TVALID  in  1  sample valid
- AXIS_TUSER  in  K_BITS+1  [K_BITS:1]=K, [0]=new_W; sampled only on the first beat of a matrix
- AXIS_TREADY  out  1  buffer accepts a beat
- inputs_loaded  out  1  W, B and X are complete and stable
- compute_finished  in  1  one-cycle pulse from the compute stage
- K  out  K_BITS  latched kernel size
- B  out  INW  latched bias
- X_read_addr  in  X_ADDR_BITS  row-major X read address
- X_data  out  INW  X read data
- W_read_addr  in  W_ADDR_BITS  row-major W read address
- W_data  out  INW  W read data

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: state IDLE; write counter 0; K=0; B=0; inputs_loaded=0; AXIS_TREADY=1 from the first cycle after reset.
- Memory contents are not cleared by reset.
- Handshake:
  - A beat is accepted when AXIS_TVALID && AXIS_TREADY at a rising edge.
  - AXIS_TREADY=1 in IDLE, LOAD_W, LOAD_B, LOAD_X; 0 in READY.
  - AXIS_TREADY is a function of state only, with no combinational path from TVALID.
- Stream order:
  - new_W=1: K*K W values (row-major), then 1 B value, then R*C X values (row-major).
  - new_W=0: R*C X values only; previous W, K and B are retained.
- States:
  - IDLE, first accepted beat with TUSER[0]=1: latch K=TUSER[K_BITS:1], write W[0]=TDATA, counter=1.
    - If K*K==1, go to LOAD_B.
    - Otherwise go to LOAD_W.
  - IDLE, first accepted beat with TUSER[0]=0: write X[0], counter=1, go to LOAD_X.
  - LOAD_W: each accepted beat writes W[counter], counter++. The beat with counter==K*K-1 resets counter to 0 and goes to LOAD_B.
  - LOAD_B: accepted beat latches B, counter=0, go to LOAD_X.
  - LOAD_X: each accepted beat writes X[counter], counter++. The beat with counter==R*C-1 resets counter to 0 and goes to READY.
  - READY: inputs_loaded=1. On compute_finished=1 go to IDLE; inputs_loaded=0 and AXIS_TREADY=1 on the next cycle.
- K/B stability: K and B are constant while inputs_loaded=1. K is updated only on the first beat of a new_W matrix.
- TUSER on later beats is ignored.
- compute_finished outside READY is ignored.
- Reads:
  - X_data and W_data are registered: data for an address presented in cycle n appears in cycle n+1.
  - Reads are permitted in every state.
  - A read of the address being written in the same cycle returns the old contents.
- Out-of-range read addresses (>=R*C, >=MAXK*MAXK) return unspecified data and have no side effects.
- K outside 1..MAXK is not supported; behaviour is undefined.
- Reset mid-load: return to IDLE, counter=0, K=0, B=0. The partial matrix is discarded, and a subsequent new_W=0 stream uses W memory contents with K=0, which is illegal; the source must resend with new_W=1.
- Latency: inputs_loaded rises on the cycle after the final X beat is accepted.

Test Plan:
- R=4, C=5, K=3, new_W=1: stream W=1..9, B=-7, X=0..19 with TVALID held high -> TREADY stays 1 for 30 beats and drops the cycle after the last X beat; inputs_loaded=1, K=3, B=-7. Read X addr 13 -> 13 one cycle later; W addr 8 -> 9.
- Random TVALID gaps (~50% duty) on the same stream -> identical memory contents and K/B; no beat lost or duplicated.
- K=1, new_W=1: W=5, B=2, then X -> the LOAD_W phase is skipped (second beat latched as B=2), K=1, inputs_loaded after R*C X beats.
- After test 1, pulse compute_finished, then send new_W=0 with X=100..119 -> W still 1..9, K=3, B=-7; X addr 0 reads 100.
- TVALID=1 with new data while READY -> no acceptance (TREADY=0) and memories unchanged until compute_finished; the first beat is accepted the cycle after IDLE is re-entered.
- Assert reset after 12 beats of a new_W=1 load -> TREADY=1, inputs_loaded=0, K=0, B=0. A fresh full stream then loads correctly.
